// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause and EPC.
// Commits exception/ERET side effects, runs the Count/Compare timer and samples interrupts.
module cp0_regs #(
   parameter int          TICK_DIV   = 2,
   parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [8:0]  except_i,
   input  logic        is_delay_slot_i,
   input  logic [31:0] cur_pc_i,
   input  logic [31:0] bad_vaddr_i,
   input  logic [5:0]  ext_int_i,
   input  logic        wr_en_i,
   input  logic [4:0]  wr_addr_i,
   input  logic [31:0] wr_data_i,
   input  logic [4:0]  rd_addr_i,
   output logic [31:0] rd_data_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic        timer_int_o
);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;

   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
   localparam logic [31:0] STATUS_BEV   = 32'h0040_0000;

   localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [31:0]   badvaddr_q, count_q, compare_q, status_q, epc_q;
   logic          bd_q, ti_q;
   logic [5:0]    ip_hw_q;
   logic [1:0]    ip_sw_q;
   logic [4:0]    exc_code_q;
   logic [TW-1:0] tick_q;

   logic          exc_take, eret, set_bva;
   logic [4:0]    exc_code_d;
   logic [31:0]   bva_d;

   // Lowest set bit wins; ERET only counts when no real exception is present.
   always_comb begin
      exc_take   = 1'b1;
      exc_code_d = 5'h00;
      set_bva    = 1'b0;
      bva_d      = cur_pc_i;
      if      (except_i[0]) exc_code_d = 5'h00;
      else if (except_i[1]) begin exc_code_d = 5'h04; set_bva = 1'b1; end
      else if (except_i[2]) exc_code_d = 5'h0A;
      else if (except_i[3]) exc_code_d = 5'h08;
      else if (except_i[4]) exc_code_d = 5'h09;
      else if (except_i[5]) exc_code_d = 5'h0C;
      else if (except_i[6]) begin exc_code_d = 5'h05; set_bva = 1'b1; bva_d = bad_vaddr_i; end
      else if (except_i[7]) begin exc_code_d = 5'h04; set_bva = 1'b1; bva_d = bad_vaddr_i; end
      else                  exc_take = 1'b0;
      eret = except_i[8] & ~exc_take;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         badvaddr_q <= '0;
         count_q    <= '0;
         compare_q  <= '0;
         status_q   <= (STATUS_RST & STATUS_WMASK) | STATUS_BEV;
         epc_q      <= '0;
         bd_q       <= 1'b0;
         ti_q       <= 1'b0;
         ip_hw_q    <= '0;
         ip_sw_q    <= '0;
         exc_code_q <= '0;
         tick_q     <= '0;
      end else begin
         if (tick_q == TICK_LAST) begin
            tick_q  <= '0;
            count_q <= count_q + 32'd1;
         end else begin
            tick_q  <= tick_q + TW'(1);
         end
         if (count_q == compare_q && compare_q != 32'd0) ti_q <= 1'b1;
         ip_hw_q <= ext_int_i;

         if (wr_en_i) begin
            case (wr_addr_i)
               REG_COUNT:   begin count_q <= wr_data_i; tick_q <= '0; end
               REG_COMPARE: begin compare_q <= wr_data_i; ti_q <= 1'b0; end
               REG_STATUS:  status_q <= (wr_data_i & STATUS_WMASK) | STATUS_BEV;
               REG_CAUSE:   ip_sw_q <= wr_data_i[9:8];
               REG_EPC:     epc_q <= wr_data_i;
               default:     ;
            endcase
         end

         // NOTE: the last non-blocking assignment to a bit wins, so the exception/ERET
         // updates below deliberately override an MTC0 to the same field on this edge.
         if (exc_take) begin
            if (!status_q[1]) begin
               epc_q <= is_delay_slot_i ? cur_pc_i - 32'd4 : cur_pc_i;
               bd_q  <= is_delay_slot_i;
            end
            exc_code_q  <= exc_code_d;
            status_q[1] <= 1'b1;
            if (set_bva) badvaddr_q <= bva_d;
         end else if (eret) begin
            status_q[1] <= 1'b0;
         end
      end
   end

   assign status_o    = status_q;
   assign epc_o       = epc_q;
   assign timer_int_o = ti_q;
   assign cause_o     = {bd_q, ti_q, 14'b0, ip_hw_q[5] | ti_q, ip_hw_q[4:0],
                         ip_sw_q, 1'b0, exc_code_q, 2'b0};

   always_comb begin
      rd_data_o = '0;
      case (rd_addr_i)
         REG_BADVADDR: rd_data_o = badvaddr_q;
         REG_COUNT:    rd_data_o = count_q;
         REG_COMPARE:  rd_data_o = compare_q;
         REG_STATUS:   rd_data_o = status_o;
         REG_CAUSE:    rd_data_o = cause_o;
         REG_EPC:      rd_data_o = epc_q;
         default:      rd_data_o = '0;
      endcase
   end

endmodule
